// File: rtl/micro_sequencer_if.sv
// rtl/micro_sequencer_if.sv - sequencing bus between microword/counter side and the micro_sequencer
interface micro_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] upc;
    logic [2:0]        seq_op;
    logic [ADDR_W-1:0] seq_target;
    logic [1:0]        cond_sel;
    logic              cond_inv;
    logic [3:0]        flags;
    logic [ADDR_W-1:0] map_addr;
    logic              stall;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] load_addr;
    logic              halted;
    logic              fault;

    // Microword / counter / datapath side
    modport master (
        output upc, seq_op, seq_target, cond_sel, cond_inv, flags, map_addr, stall,
        input  cmd, load_addr, halted, fault
    );

    // Sequencer side
    modport slave (
        input  upc, seq_op, seq_target, cond_sel, cond_inv, flags, map_addr, stall,
        output cmd, load_addr, halted, fault
    );
endinterface

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - next-address control with return-address stack and halt state
module micro_sequencer #(
    parameter int                ADDR_W      = 11,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] FAULT_VEC   = 11'h7F0
) (
    input  logic              clk,
    input  logic              reset,
    micro_sequencer_if.slave  bus
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_INC  = 2'd1;
    localparam logic [1:0] CMD_LOAD = 2'd2;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BRANCH   = 3'd2;
    localparam logic [2:0] OP_DISPATCH = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RETURN   = 3'd5;
    localparam logic [2:0] OP_WAIT     = 3'd6;
    localparam logic [2:0] OP_HALT     = 3'd7;

    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] stack_q [2**IDX_W];

    logic              cond;
    logic              do_push, do_pop, stack_err, halt_req;
    logic [1:0]        cmd_o;
    logic [ADDR_W-1:0] load_addr_o;
    logic [SP_W-1:0]   sp_m1;
    logic [ADDR_W-1:0] ret_addr;

    assign cond     = bus.flags[bus.cond_sel] ^ bus.cond_inv;
    assign sp_m1    = sp_q - 1'b1;
    assign ret_addr = bus.upc + 1'b1;

    // State, stack pointer and sticky fault registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            sp_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end

    // Return-address storage; contents need no reset, sp alone defines validity
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            stack_q[sp_q[IDX_W-1:0]] <= ret_addr;
        end
    end

    // Next-state: halt entry, stack pointer movement, fault latching
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        fault_d = fault_q;
        if (halt_req) begin
            state_d = S_HALTED;
        end
        if (stack_err) begin
            sp_d    = '0;
            fault_d = 1'b1;
        end else if (do_push) begin
            sp_d = sp_q + 1'b1;
        end else if (do_pop) begin
            sp_d = sp_m1;
        end
    end

    // Output decode: counter command, load address and stack strobes for this cycle
    always_comb begin
        cmd_o       = CMD_NONE;
        load_addr_o = '0;
        do_push     = 1'b0;
        do_pop      = 1'b0;
        stack_err   = 1'b0;
        halt_req    = 1'b0;
        if (!reset && state_q == S_RUN && !bus.stall) begin
            case (bus.seq_op)
                OP_NEXT: cmd_o = CMD_INC;
                OP_JUMP: begin
                    cmd_o       = CMD_LOAD;
                    load_addr_o = bus.seq_target;
                end
                OP_BRANCH: begin
                    if (cond) begin
                        cmd_o       = CMD_LOAD;
                        load_addr_o = bus.seq_target;
                    end else begin
                        cmd_o = CMD_INC;
                    end
                end
                OP_DISPATCH: begin
                    cmd_o       = CMD_LOAD;
                    load_addr_o = bus.map_addr;
                end
                OP_CALL: begin
                    cmd_o = CMD_LOAD;
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        stack_err   = 1'b1;
                        load_addr_o = FAULT_VEC;
                    end else begin
                        do_push     = 1'b1;
                        load_addr_o = bus.seq_target;
                    end
                end
                OP_RETURN: begin
                    cmd_o = CMD_LOAD;
                    if (sp_q == '0) begin
                        stack_err   = 1'b1;
                        load_addr_o = FAULT_VEC;
                    end else begin
                        do_pop      = 1'b1;
                        load_addr_o = stack_q[sp_m1[IDX_W-1:0]];
                    end
                end
                OP_WAIT: cmd_o = cond ? CMD_INC : CMD_NONE;
                OP_HALT: halt_req = 1'b1;
                default: cmd_o = CMD_NONE;
            endcase
        end
    end

    assign bus.cmd       = cmd_o;
    assign bus.load_addr = load_addr_o;
    assign bus.halted    = (state_q == S_HALTED);
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    micro_sequencer_if #(.ADDR_W(11)) bus ();

    micro_sequencer #(.ADDR_W(11), .STACK_DEPTH(4), .FAULT_VEC(11'h7F0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  op;
        logic [10:0] upc;
        logic [10:0] tgt;
        logic [1:0]  csel;
        logic        cinv;
        logic [3:0]  flg;
        logic [10:0] map;
        logic        stl;
        logic [1:0]  e_cmd;
        logic [10:0] e_load;
        logic        chk_st;
        logic        e_halted;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic rst, input logic [2:0] op, input logic [10:0] upc,
                         input logic [10:0] tgt, input logic [1:0] csel, input logic cinv,
                         input logic [3:0] flg, input logic [10:0] map, input logic stl);
        @(negedge clk);
        reset          = rst;
        bus.seq_op     = op;
        bus.upc        = upc;
        bus.seq_target = tgt;
        bus.cond_sel   = csel;
        bus.cond_inv   = cinv;
        bus.flags      = flg;
        bus.map_addr   = map;
        bus.stall      = stl;
        #1;
    endtask

    task automatic chk_out(input string name, input logic [1:0] e_cmd, input logic [10:0] e_load);
        checks++;
        if (bus.cmd !== e_cmd || bus.load_addr !== e_load) begin
            errors++;
            $display("FAIL %s: cmd=%0d load_addr=0x%03h, expected cmd=%0d load_addr=0x%03h",
                     name, bus.cmd, bus.load_addr, e_cmd, e_load);
        end
    endtask

    task automatic chk_st(input string name, input logic e_halted, input logic e_fault);
        checks++;
        if (bus.halted !== e_halted || bus.fault !== e_fault) begin
            errors++;
            $display("FAIL %s: halted=%0b fault=%0b, expected halted=%0b fault=%0b",
                     name, bus.halted, bus.fault, e_halted, e_fault);
        end
    endtask

    task automatic add(input string name, input logic rst, input logic [2:0] op,
                       input logic [10:0] upc, input logic [10:0] tgt, input logic [1:0] csel,
                       input logic cinv, input logic [3:0] flg, input logic [10:0] map,
                       input logic stl, input logic [1:0] e_cmd, input logic [10:0] e_load,
                       input logic cs, input logic eh, input logic ef);
        vec_t v;
        v = '{name, rst, op, upc, tgt, csel, cinv, flg, map, stl, e_cmd, e_load, cs, eh, ef};
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1;
        bus.seq_op = '0; bus.upc = '0; bus.seq_target = '0; bus.cond_sel = '0;
        bus.cond_inv = 1'b0; bus.flags = '0; bus.map_addr = '0; bus.stall = 1'b0;

        //   name            rst op  upc     tgt     cs cinv flags    map     stl cmd load   chk h  f
        add("reset_out",     1, 1, 11'h000, 11'h055, 0, 0, 4'b0000, 11'h000, 0, 0, 11'h000, 0, 0, 0);
        add("next",          0, 0, 11'h005, 11'h000, 0, 0, 4'b0000, 11'h000, 0, 1, 11'h000, 1, 0, 0);
        add("branch_taken",  0, 2, 11'h006, 11'h120, 2, 0, 4'b0100, 11'h000, 0, 2, 11'h120, 1, 0, 0);
        add("branch_inv",    0, 2, 11'h007, 11'h120, 2, 1, 4'b0100, 11'h000, 0, 1, 11'h000, 1, 0, 0);
        add("branch_nt",     0, 2, 11'h008, 11'h120, 0, 0, 4'b0100, 11'h000, 0, 1, 11'h000, 1, 0, 0);
        add("jump",          0, 1, 11'h009, 11'h0AB, 0, 0, 4'b0000, 11'h000, 0, 2, 11'h0AB, 1, 0, 0);
        add("dispatch",      0, 3, 11'h00A, 11'h0AB, 0, 0, 4'b0000, 11'h345, 0, 2, 11'h345, 1, 0, 0);
        add("call_outer",    0, 4, 11'h010, 11'h200, 0, 0, 4'b0000, 11'h000, 0, 2, 11'h200, 1, 0, 0);
        add("call_inner",    0, 4, 11'h205, 11'h300, 0, 0, 4'b0000, 11'h000, 0, 2, 11'h300, 1, 0, 0);
        add("ret_inner",     0, 5, 11'h300, 11'h000, 0, 0, 4'b0000, 11'h000, 0, 2, 11'h206, 1, 0, 0);
        add("ret_outer",     0, 5, 11'h206, 11'h000, 0, 0, 4'b0000, 11'h000, 0, 2, 11'h011, 1, 0, 0);
        add("ret_sp_zero",   0, 5, 11'h011, 11'h000, 0, 0, 4'b0000, 11'h000, 0, 2, 11'h7F0, 1, 0, 0);
        add("fault_sticky",  0, 6, 11'h7F0, 11'h000, 1, 0, 4'b0010, 11'h000, 0, 1, 11'h000, 1, 0, 1);
        add("reset_prio",    1, 5, 11'h7F1, 11'h000, 0, 0, 4'b0000, 11'h000, 1, 0, 11'h000, 1, 0, 1);
        add("underflow",     0, 5, 11'h000, 11'h000, 0, 0, 4'b0000, 11'h000, 0, 2, 11'h7F0, 1, 0, 0);
        add("after_uflow",   0, 0, 11'h7F0, 11'h000, 0, 0, 4'b0000, 11'h000, 0, 1, 11'h000, 1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].upc, vecs[i].tgt, vecs[i].csel,
                  vecs[i].cinv, vecs[i].flg, vecs[i].map, vecs[i].stl);
            chk_out(vecs[i].name, vecs[i].e_cmd, vecs[i].e_load);
            if (vecs[i].chk_st) chk_st(vecs[i].name, vecs[i].e_halted, vecs[i].e_fault);
        end

        // Overflow: four CALLs fill the stack, the fifth faults and clears sp
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 4, 11'h100 + 11'(i), 11'h400 + 11'(i), 0, 0, 0, 0, 0);
            chk_out("ovf_fill", 2'd2, 11'h400 + 11'(i));
        end
        drive(0, 4, 11'h403, 11'h500, 0, 0, 0, 0, 0);
        chk_out("ovf_call5", 2'd2, 11'h7F0);
        chk_st("ovf_call5_pre", 0, 0);
        drive(0, 5, 11'h7F0, 0, 0, 0, 0, 0, 0);
        chk_st("ovf_fault", 0, 1);
        chk_out("ovf_sp_clear", 2'd2, 11'h7F0);

        // Stalled CALL: no push while stalled, exactly one push on release
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4, 11'h020, 11'h222, 0, 0, 0, 0, 1);
            chk_out("stall_call", 2'd0, 11'h000);
        end
        drive(0, 4, 11'h020, 11'h222, 0, 0, 0, 0, 0);
        chk_out("stall_release", 2'd2, 11'h222);
        drive(0, 5, 11'h222, 0, 0, 0, 0, 0, 0);
        chk_out("stall_ret", 2'd2, 11'h021);
        drive(0, 5, 11'h021, 0, 0, 0, 0, 0, 0);
        chk_out("stall_one_push", 2'd2, 11'h7F0);

        // WAIT holds the counter until the condition rises
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 6, 11'h030, 0, 3, 0, 4'b0000, 0, 0);
            chk_out("wait_hold", 2'd0, 11'h000);
        end
        drive(0, 6, 11'h030, 0, 3, 0, 4'b1000, 0, 0);
        chk_out("wait_go", 2'd1, 11'h000);

        // HALT: deferred by stall, then sticky against later ops until reset
        drive(0, 7, 11'h3FF, 0, 0, 0, 0, 0, 1);
        chk_out("halt_stalled", 2'd0, 11'h000);
        drive(0, 7, 11'h3FF, 0, 0, 0, 0, 0, 0);
        chk_st("halt_deferred", 0, 0);
        chk_out("halt", 2'd0, 11'h000);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 11'h3FF, 11'h123, 0, 0, 0, 0, 1'(i));
            chk_st("halted", 1, 0);
            chk_out("halted_jump", 2'd0, 11'h000);
        end
        drive(1, 1, 11'h3FF, 11'h123, 0, 0, 0, 0, 0);
        drive(0, 4, 11'h7FF, 11'h050, 0, 0, 0, 0, 0);
        chk_st("halt_cleared", 0, 0);
        chk_out("call_wrap", 2'd2, 11'h050);
        drive(0, 5, 11'h050, 0, 0, 0, 0, 0, 0);
        chk_out("ret_wrap", 2'd2, 11'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Next-address control unit of the microcoded CPU. It decodes the sequencing field of the current microinstruction, status flags and the opcode dispatch address, and drives the command and load address into the micro-address counter. It owns the microcode return-address stack and the halt state. The counter applies the command on the following clock edge.

## Interface
- ADDR_W, 11, micro-address width; must match the counter.
- STACK_DEPTH, 4, return-address stack entries, 1..8.
- FAULT_VEC, 11'h7F0, microcode entry loaded on stack overflow or underflow.
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- upc  in  ADDR_W  current micro-address from the counter
- seq_op  in  3  sequencing op of current microword
- seq_target  in  ADDR_W  target field of current microword
- cond_sel  in  2  selects flags bit for BRANCH/WAIT
- cond_inv  in  1  inverts the selected condition
- flags  in  4  datapath status flags
- map_addr  in  ADDR_W  dispatch-ROM address for the current opcode
- stall  in  1  memory/bus not ready; freezes sequencing
- cmd  out  2  counter command: 0 NONE, 1 INC, 2 LOAD; 3 is never driven
- load_addr  out  ADDR_W  address used by the counter when cmd is LOAD
- halted  out  1  high while in HALTED
- fault  out  1  sticky stack error flag

## Operation
- cond = flags[cond_sel] XOR cond_inv.
- States:
  - RUN: decode seq_op.
  - HALTED: cmd=NONE regardless of inputs; exit only by reset.
- seq_op decode in RUN:
  - 0 NEXT: INC.
  - 1 JUMP: LOAD seq_target.
  - 2 BRANCH: LOAD seq_target if cond, else INC.
  - 3 DISPATCH: LOAD map_addr.
  - 4 CALL: push (upc+1) mod 2^ADDR_W; LOAD seq_target.
  - 5 RETURN: pop; LOAD popped value.
  - 6 WAIT: NONE while cond=0; INC when cond=1.
  - 7 HALT: NONE; go to HALTED at the edge.
- Stack, with sp in 0..STACK_DEPTH:
  - Push writes entry[sp] and increments sp.
  - Pop reads entry[sp-1] and decrements sp.
- Overflow is CALL with sp==STACK_DEPTH. Underflow is RETURN with sp==0. On either:
  - cmd=LOAD, load_addr=FAULT_VEC.
  - No push or pop.
  - sp cleared to 0.
  - fault set; it stays set until reset.
  - State stays RUN.
- stall=1 in RUN: cmd=NONE, load_addr=0. No change to stack, sp, state or fault; the op is re-evaluated when stall drops.
- load_addr is 0 whenever cmd is not LOAD.

## Timing
- cmd and load_addr are combinational from the inputs and registered state in the same cycle. There is no pipeline latency; the counter updates upc at the next edge.
- sp, stack entries, state and fault update on the rising edge only.
- A CALL/RETURN pair executed back to back returns to call_site+1.
- Reset cycle outputs: cmd=NONE, load_addr=0.
- Registered state after reset: sp=0, state=RUN, halted=0, fault=0. Stack entry contents are don't-care.
- Reset mid-CALL or mid-RETURN discards the push or pop. Reset has priority over stall and all ops.
- HALT with stall=1 does not halt until stall drops.
- In HALTED, stall has no effect.

## Test plan
- Reset, then NEXT with upc=5 -> cmd=1, load_addr=0; halted=0, fault=0.
- BRANCH, target=0x120, cond_sel=2, flags=4'b0100:
  - cond_inv=0 -> cmd=2, load_addr=0x120.
  - cond_inv=1 -> cmd=1, load_addr=0.
- Nested calls:
  - CALL at upc=0x010 (target 0x200), then CALL at upc=0x205 (target 0x300).
  - Then RETURN twice -> load_addr=0x206, then 0x011.
  - sp ends at 0 and fault stays 0.
- Overflow and underflow:
  - Fill the stack with 4 CALLs; a 5th CALL -> cmd=2, load_addr=0x7F0, fault=1, sp=0.
  - After reset, RETURN with an empty stack -> the same response.
- Stall and WAIT:
  - CALL with stall=1 for 3 cycles -> cmd=0 and sp unchanged throughout.
  - On release, the push happens exactly once.
  - WAIT with cond=0 for 5 cycles, then cond=1 -> cmd=0 x5, then cmd=1.
- HALT with upc=0x3FF -> cmd=0, halted=1 next cycle, and it stays halted under JUMP inputs. Reset clears halted; a CALL at upc=0x7FF pushes 0x000.
